// File: rtl/stb_pkg.sv
// Shared types and helpers for the store buffer: access modes, entry layout, mode decode.
package stb_pkg;

    localparam int STB_AW = 8;
    localparam int STB_DW = 32;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_WORD = 2'b10;

    typedef struct packed {
        logic [STB_AW-1:0] adr;
        logic [1:0]        mode;
        logic [STB_DW-1:0] data;
    } stb_entry_t;

    // Any mode with bit 1 set is a full-word access.
    function automatic logic is_word(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/stb_match.sv
// Youngest-entry address match over the pending window of the store buffer.
// Walks oldest to youngest so that a later hit overrides an earlier one.
module stb_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [AW-1:0]            ld_adr,
    input  logic [DEPTH-1:0][AW-1:0] adrs,
    input  logic [DEPTH-1:0][1:0]    modes,
    input  logic [PW-1:0]            rd_ptr,
    input  logic [PW:0]              count,
    output logic                     hit,
    output logic [PW-1:0]            idx,
    output logic                     is_word
);

    always_comb begin
        logic [PW-1:0] slot;
        hit     = 1'b0;
        idx     = '0;
        is_word = 1'b0;
        slot    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && (adrs[slot] == ld_adr)) begin
                hit     = 1'b1;
                idx     = slot;
                is_word = stb_pkg::is_word(modes[slot]);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core store path and the data memory port, with load matching.
// Define STB_FWD_EN to forward word stores to matching loads; otherwise any match stalls the load.
module store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_adr,
    input  logic [1:0]    st_mode,
    input  logic [DW-1:0] st_data,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_adr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          ld_stall,
    output logic          empty,
    output logic          dm_wr,
    output logic [AW-1:0] dm_adr,
    output logic [1:0]    dm_mode,
    output logic [DW-1:0] dm_wd
);

    localparam int PW = $clog2(DEPTH);

    stb_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          enq;
    logic          drain;
    stb_entry_t    head;

    logic [DEPTH-1:0][AW-1:0] adrs;
    logic [DEPTH-1:0][1:0]    modes;
    logic                     m_hit;
    logic [PW-1:0]            m_idx;
    logic                     m_word;

    assign empty    = (count == '0);
    // No full-bypass: a drain in the same cycle does not free a slot early.
    assign st_ready = (count != (PW+1)'(DEPTH));
    assign enq      = st_valid && st_ready;
    assign drain    = !empty && !ld_valid;
    assign dm_wr    = drain;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{adr: '0, mode: MODE_BYTE, data: '0};
            end
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{adr: st_adr, mode: st_mode, data: st_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (drain) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (enq && !drain) begin
                count <= count + (PW+1)'(1);
            end else if (!enq && drain) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    always_comb begin
        dm_adr  = '0;
        dm_mode = '0;
        dm_wd   = '0;
        if (!empty) begin
            dm_adr  = head.adr;
            dm_mode = head.mode;
            dm_wd   = head.data;
        end
        if (ld_valid && reset) begin
            dm_adr = ld_adr;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            adrs[i]  = mem[i].adr;
            modes[i] = mem[i].mode;
        end
    end

    stb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .ld_adr  (ld_adr),
        .adrs    (adrs),
        .modes   (modes),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .hit     (m_hit),
        .idx     (m_idx),
        .is_word (m_word)
    );

`ifdef STB_FWD_EN
    assign fwd_hit  = ld_valid && m_hit && m_word;
    assign ld_stall = ld_valid && m_hit && !m_word;
    assign fwd_data = fwd_hit ? mem[m_idx].data : '0;
`else
    logic unused_match;
    assign unused_match = ^{m_word, m_idx};
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign ld_stall = ld_valid && m_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, fill/drain, forwarding, partial conflict, wrap, mid-drain reset.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [7:0]  st_adr;
    logic [1:0]  st_mode;
    logic [31:0] st_data;
    logic        ld_valid;
    logic [7:0]  ld_adr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        ld_stall;
    logic        empty;
    logic        dm_wr;
    logic [7:0]  dm_adr;
    logic [1:0]  dm_mode;
    logic [31:0] dm_wd;

    int n_chk = 0;
    int n_bad = 0;

    logic [7:0]  log_adr  [$];
    logic [31:0] log_data [$];

    store_buffer #(.DEPTH(4), .AW(8), .DW(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_adr   (st_adr),
        .st_mode  (st_mode),
        .st_data  (st_data),
        .ld_valid (ld_valid),
        .ld_adr   (ld_adr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .ld_stall (ld_stall),
        .empty    (empty),
        .dm_wr    (dm_wr),
        .dm_adr   (dm_adr),
        .dm_mode  (dm_mode),
        .dm_wd    (dm_wd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_wr) begin
            log_adr.push_back(dm_adr);
            log_data.push_back(dm_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stage(input logic [7:0] adr, input logic [1:0] mode, input logic [31:0] data);
        st_valid = 1'b1;
        st_adr   = adr;
        st_mode  = mode;
        st_data  = data;
    endtask

    task automatic wait_empty(input string tag, input int max);
        int n = 0;
        while (!empty && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(empty), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        st_valid = 1'b0;
        st_adr   = '0;
        st_mode  = '0;
        st_data  = '0;
        ld_valid = 1'b0;
        ld_adr   = '0;

        // T1 reset
        #3;
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_ready", 32'(st_ready), 32'd1);
        chk("t1_dmwr", 32'(dm_wr), 32'd0);
        chk("t1_dmadr", 32'(dm_adr), 32'd0);
        chk("t1_stall", 32'(ld_stall), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        chk("t1_nowr", 32'(log_adr.size()), 32'd0);

        // T2 fill then drain
        ld_valid = 1'b1;
        ld_adr   = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            stage(8'(i), 2'b10, 32'h000000A0 + 32'(i));
            #1;
            chk("t2_ready", 32'(st_ready), 32'd1);
            tick();
        end
        st_valid = 1'b0;
        #1;
        chk("t2_full", 32'(st_ready), 32'd0);
        chk("t2_ldhold", 32'(dm_wr), 32'd0);
        chk("t2_ldadr", 32'(dm_adr), 32'h00);
        ld_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t2_dmwr", 32'(dm_wr), 32'd1);
            chk("t2_dmadr", 32'(dm_adr), 32'(i));
            chk("t2_dmwd", dm_wd, 32'h000000A0 + 32'(i));
            tick();
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // T3 forwarding of youngest word store
        ld_valid = 1'b1;
        ld_adr   = 8'h00;
        stage(8'h05, 2'b10, 32'hDEADBEEF);
        tick();
        stage(8'h05, 2'b10, 32'h12345678);
        tick();
        st_valid = 1'b0;
        ld_adr   = 8'h05;
        #1;
`ifdef STB_FWD_EN
        chk("t3_hit", 32'(fwd_hit), 32'd1);
        chk("t3_data", fwd_data, 32'h12345678);
        chk("t3_stall", 32'(ld_stall), 32'd0);
`else
        chk("t3_hit", 32'(fwd_hit), 32'd0);
        chk("t3_data", fwd_data, 32'h0);
        chk("t3_stall", 32'(ld_stall), 32'd1);
`endif
        ld_valid = 1'b0;
        #1;
        chk("t3_noload", 32'(ld_stall), 32'd0);
        wait_empty("t3_drain", 8);

        // T4 partial-width conflict stalls
        ld_valid = 1'b1;
        ld_adr   = 8'h00;
        stage(8'h07, 2'b00, 32'h000000AB);
        tick();
        st_valid = 1'b0;
        ld_adr   = 8'h07;
        #1;
        chk("t4_stall", 32'(ld_stall), 32'd1);
        chk("t4_hit", 32'(fwd_hit), 32'd0);
        tick();
        ld_valid = 1'b0;
        #1;
        chk("t4_dmwr", 32'(dm_wr), 32'd1);
        chk("t4_dmadr", 32'(dm_adr), 32'h07);
        chk("t4_dmmode", 32'(dm_mode), 32'd0);
        chk("t4_dmwd", dm_wd, 32'h000000AB);
        tick();
        ld_valid = 1'b1;
        #1;
        chk("t4_retry", 32'(ld_stall), 32'd0);
        chk("t4_rhit", 32'(fwd_hit), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        ld_valid = 1'b0;

        // T5 wrap with simultaneous enqueue/drain
        log_adr.delete();
        log_data.delete();
        ld_valid = 1'b1;
        ld_adr   = 8'hFF;
        stage(8'h10, 2'b10, 32'hC0);
        tick();
        stage(8'h11, 2'b10, 32'hC1);
        tick();
        ld_valid = 1'b0;
        stage(8'h12, 2'b10, 32'hC2);
        #1;
        chk("t5_both", 32'(dm_wr), 32'd1);
        tick();
        ld_valid = 1'b1;
        stage(8'h13, 2'b10, 32'hC3);
        tick();
        stage(8'h14, 2'b10, 32'hC4);
        #1;
        chk("t5_cnt3", 32'(st_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        stage(8'h15, 2'b10, 32'hC5);
        #1;
        chk("t5_nobypass", 32'(st_ready), 32'd0);
        tick();
        #1;
        chk("t5_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        wait_empty("t5_drain", 10);
        chk("t5_nwr", 32'(log_adr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < log_adr.size()) begin
                chk("t5_adr", 32'(log_adr[i]), 32'h10 + 32'(i));
                chk("t5_data", log_data[i], 32'hC0 + 32'(i));
            end
        end

        // T6 reset during drain discards pending stores
        log_adr.delete();
        log_data.delete();
        ld_valid = 1'b1;
        ld_adr   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            stage(8'h20 + 8'(i), 2'b10, 32'hE0 + 32'(i));
            tick();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;
        #1;
        chk("t6_pre", 32'(dm_wr), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_dmwr", 32'(dm_wr), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_dmadr", 32'(dm_adr), 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("t6_nowr", 32'(log_adr.size()), 32'd0);
        chk("t6_ready", 32'(st_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
